// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// one-hot result encoding that maps directly onto the {L, G, EQ} outputs.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2:0] res_t;

    // RES_NONE doubles as "no decision yet" while scanning and "outputs low" in RUN.
    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_EQ   = 3'b001;
    localparam res_t RES_G    = 3'b010;
    localparam res_t RES_L    = 3'b100;

    function automatic res_t decision(input logic a_greater);
        return a_greater ? RES_G : RES_L;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle between a comparator client (master) and the
// comparator itself (slave).
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             EQ;
    logic             G;
    logic             L;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, EQ, G, L
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, EQ, G, L
    );
endinterface

// File: rtl/serial_cmp_cell.sv
// One-bit decision for an MSB-first scan: does this pair differ, and if so
// is A the larger operand.
module serial_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic signed_mode,
    output logic differ,
    output logic a_greater
);
    assign differ = a_bit ^ b_bit;

    // At the two's-complement sign bit the operand holding a 1 is the negative one.
    assign a_greater = differ & (a_bit ^ (is_msb & signed_mode));
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans one captured bit pair per cycle,
// MSB first, and latches a one-hot EQ/G/L result with a one-cycle done pulse.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    serial_magnitude_comparator_if.slave   bus
);
    localparam int             IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_magnitude_comparator: WIDTH must be 2..64");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sm_q, sm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    res_t              dec_q, dec_d;
    res_t              res_q, res_d;

    logic              differ;
    logic              a_greater;
    res_t              cur;

    serial_cmp_cell u_cell (
        .a_bit       (a_q[idx_q]),
        .b_bit       (b_q[idx_q]),
        .is_msb      (idx_q == IDX_MSB),
        .signed_mode (sm_q),
        .differ      (differ),
        .a_greater   (a_greater)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sm_q  <= 1'b0;
            idx_q <= '0;
            dec_q <= RES_NONE;
            res_q <= RES_NONE;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sm_q  <= sm_d;
            idx_q <= idx_d;
            dec_q <= dec_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        res_d   = res_q;
        cur     = dec_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sm_d    = bus.signed_mode;
                    idx_d   = IDX_MSB;
                    dec_d   = RES_NONE;
                    res_d   = RES_NONE;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                // Only the first differing pair may set the decision.
                if (differ && dec_q == RES_NONE) begin
                    cur = decision(a_greater);
                end
                if (idx_q == '0 || (EARLY_EXIT && cur != RES_NONE)) begin
                    res_d   = (cur == RES_NONE) ? RES_EQ : cur;
                    state_d = DONE;
                end else begin
                    dec_d = cur;
                    idx_d = idx_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.EQ   = res_q[0];
    assign bus.G    = res_q[1];
    assign bus.L    = res_q[2];

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be legal for 2..64.
REQ-002 Parameter EARLY_EXIT, default 1, 1 = finish at the first differing bit, 0 = always scan all WIDTH bits.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 start  input  1  request a comparison of A and B.
REQ-006 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse marking the result as valid.
REQ-011 EQ  output  1  A = B.
REQ-012 G  output  1  A > B.
REQ-013 L  output  1  A < B.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture A, B and signed_mode into internal registers, set bit index to WIDTH-1 and enter RUN on the next edge.
REQ-016 In RUN, start SHALL be ignored, and changes on A, B and signed_mode SHALL have no effect.
REQ-017 In RUN, each cycle SHALL examine exactly one captured bit pair, MSB first, at the current index.
REQ-018 On an unequal bit pair at index p: unsigned, or signed with p<WIDTH-1, A bit 1 SHALL decide G and A bit 0 SHALL decide L.
REQ-019 When signed_mode=1 and the unequal pair is at p=WIDTH-1, A bit 1 SHALL decide L and A bit 0 SHALL decide G.
REQ-020 The first decision SHALL be final; later bit pairs SHALL NOT change it.
REQ-021 EARLY_EXIT=1: RUN SHALL move to DONE on the edge ending the deciding cycle, or after index 0 if no bit pair differs.
REQ-022 EARLY_EXIT=0: RUN SHALL always last exactly WIDTH cycles.
REQ-023 If no bit pair differs, the result SHALL be EQ.
REQ-024 Latency, with start accepted in cycle 0:
- EARLY_EXIT=0: done SHALL be high in cycle WIDTH+1.
- EARLY_EXIT=1, first difference at p: done SHALL be high in cycle WIDTH-p+1.
- EARLY_EXIT=1, equal operands: done SHALL be high in cycle WIDTH+1.
REQ-025 On entry to DONE, exactly one of EQ/G/L SHALL be 1 and done SHALL be 1 for that single cycle.
REQ-026 EQ/G/L SHALL hold their values until the next accepted start.
REQ-027 EQ/G/L SHALL all be 0 during RUN.
REQ-028 DONE without start SHALL return to IDLE on the next edge.
REQ-029 start held high SHALL give back-to-back comparisons: DONE -> RUN with no IDLE cycle.
REQ-030 busy SHALL equal (state == RUN).

Reset
REQ-031 While rst=1: state SHALL be IDLE, and busy, done, EQ, G, L and the captured registers SHALL be 0, regardless of clk.
REQ-032 rst asserted mid-RUN SHALL abort the comparison, and no done pulse SHALL follow.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-034 Shared package serial_cmp_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the result encoding constants (RES_EQ, RES_G, RES_L).
REQ-035 Sub-module serial_cmp_cell SHALL hold the combinational one-bit decision: inputs a_bit, b_bit, is_msb, signed_mode; outputs differ, a_greater.
REQ-036 The index counter SHALL be $clog2(WIDTH) bits wide and SHALL count down without wrapping.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- WIDTH=8, EARLY_EXIT=1, unsigned, A=0x80, B=0x7F -> done in cycle 2, G=1.
- WIDTH=8, EARLY_EXIT=1, signed, A=0x80 (-128), B=0x7F -> done in cycle 2, L=1.
- WIDTH=8, EARLY_EXIT=0, A=B=0x5A -> busy for cycles 1..8, done in cycle 9, EQ=1; results held 3 further cycles.
- WIDTH=8, EARLY_EXIT=1, A=0x11, B=0x10 -> done in cycle 9, G=1; start pulsed in cycles 3 and 4 is ignored.
- start held high with pairs (3,5) then (5,3) -> second RUN starts immediately after the first done; results L then G.
- rst asserted in cycle 4 of a RUN -> all outputs 0 immediately, no done; a following start with A=B=0 -> EQ=1.
